fetch_buffer: RTL and testbench

- Instruction prefetch queue between the instruction memory and the IF/ID pipeline register.
- Generates sequential fetch addresses and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned {PC, IR} pairs in a small FIFO and presents them to the decode side under a valid/stall handshake.
- Flushes the queue and redirects fetch when EXE resolves a taken branch.

---
 rtl/fetch_buffer_pkg.sv | 15 +
 rtl/fetch_buffer_if.sv | 29 ++
 rtl/fb_fifo.sv | 53 +++++
 rtl/fetch_buffer.sv | 94 +++++++++
 tb/tb_fetch_buffer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared constants and request-FSM encoding for the instruction fetch buffer.
package fetch_buffer_pkg;

    localparam int unsigned FB_WIDTH = 32;

    // All-zero instruction word presented to decode when the queue is empty.
    localparam logic [FB_WIDTH-1:0] FB_NOP = '0;

    typedef enum logic [1:0] {
        FB_IDLE = 2'd0,
        FB_WAIT = 2'd1,
        FB_DROP = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/response and decode-side handshake of the fetch buffer.
interface fetch_buffer_if
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = FB_WIDTH
) ();

    logic             imem_req;
    logic [WIDTH-3:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;
    logic             IsBranch;
    logic [WIDTH-3:0] BranchAddr;
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] IR;
    logic [WIDTH-3:0] PC;

    modport master (
        output imem_req, imem_addr, valid, IR, PC,
        input  imem_ack, imem_data, IsBranch, BranchAddr, stall
    );

    modport slave (
        input  imem_req, imem_addr, valid, IR, PC,
        output imem_ack, imem_data, IsBranch, BranchAddr, stall
    );

endinterface

// File: rtl/fb_fifo.sv
// Circular FIFO with synchronous clear; the head entry is read straight from storage.
module fb_fifo #(
    parameter int unsigned WIDTH = 62,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    // DEPTH is a power of two, so the count MSB alone marks a full queue.
    assign full  = count_q[PW];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: single-outstanding sequential fetch into a small {PC, IR} FIFO,
// flushed and redirected by a taken branch from EXE.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned      WIDTH    = FB_WIDTH,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-3:0] PC_RESET = '0
) (
    input logic            clk,
    input logic            rst,
    fetch_buffer_if.master bus
);

    localparam int unsigned AW = WIDTH - 2;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fb_state_e           state_q, state_d;
    logic [AW-1:0]       fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]       req_addr_q, req_addr_d;
    logic                push, pop, full, valid;
    logic [CW-1:0]       count;
    logic [WIDTH+AW-1:0] head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FB_IDLE;
            fetch_pc_q <= PC_RESET;
            req_addr_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            FB_IDLE: begin
                if (!bus.IsBranch && !full) begin
                    state_d    = FB_WAIT;
                    req_addr_d = fetch_pc_q;
                end
            end
            FB_WAIT: begin
                if (bus.imem_ack) begin
                    state_d = FB_IDLE;
                    if (!bus.IsBranch) fetch_pc_d = fetch_pc_q + AW'(1);
                end else if (bus.IsBranch) begin
                    state_d = FB_DROP;
                end
            end
            FB_DROP: begin
                if (bus.imem_ack) state_d = FB_IDLE;
            end
            default: state_d = FB_IDLE;
        endcase
        // The redirect target wins everywhere; in DROP it is the only thing that changes.
        if (bus.IsBranch) fetch_pc_d = bus.BranchAddr;
    end

    always_comb begin
        valid         = (count != '0);
        push          = (state_q == FB_WAIT) && bus.imem_ack && !bus.IsBranch;
        pop           = valid && !bus.stall && !bus.IsBranch;
        bus.imem_req  = (state_q != FB_IDLE);
        bus.imem_addr = req_addr_q;
        bus.valid     = valid;
        bus.IR        = valid ? head[WIDTH-1:0] : WIDTH'(FB_NOP);
        bus.PC        = valid ? head[WIDTH+AW-1:WIDTH] : '0;
    end

    fb_fifo #(
        .WIDTH(WIDTH + AW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clear(bus.IsBranch),
        .push (push),
        .pop  (pop),
        .wdata({bus.imem_addr, bus.imem_data}),
        .rdata(head),
        .count(count),
        .full (full)
    );

    // Issue only happens with space left and pushes wait for that one ack, so no overflow.
    no_overflow_a: assert property (@(posedge clk) disable iff (rst) push |-> !full);

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a variable-latency memory model queues expected {PC, IR} pairs
// which are compared against the decode-side head every cycle.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int unsigned WIDTH = FB_WIDTH;
    localparam int unsigned AW    = WIDTH - 2;
    localparam int unsigned DEPTH = 4;

    typedef enum int {MIdle, MWait, MDrop} mstate_e;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_buffer_if #(.WIDTH(WIDTH)) bus ();

    fetch_buffer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PC_RESET({AW{1'b0}})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int                  n_cmp = 0;
    int                  n_bad = 0;
    mstate_e             m_state = MIdle;
    logic [AW-1:0]       m_pc = '0;
    logic [AW-1:0]       m_addr = '0;
    logic [AW-1:0]       last_pc = '0;
    logic                have_last = 1'b0;
    logic [WIDTH+AW-1:0] sb_q[$];
    logic [AW-1:0]       pop_log[$];
    logic                mem_busy = 1'b0;
    int                  lat_left = 0;
    int                  lat_min = 1;
    int                  lat_max = 1;
    logic                fixed_en = 1'b0;
    logic [WIDTH-1:0]    fixed_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: check outputs, drive inputs, advance the model, move to next negedge.
    task automatic tick(input logic stl, input logic br, input logic [AW-1:0] br_addr,
                        input logic force_ack);
        int                  sz;
        logic                ack, push, pop;
        logic [WIDTH-1:0]    data;
        logic [WIDTH+AW-1:0] ent;
        logic [AW-1:0]       nxt;
        sz = sb_q.size();
        check("imem_req", 64'(bus.imem_req), 64'(m_state != MIdle));
        if (m_state != MIdle) check("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
        check("valid", 64'(bus.valid), 64'(sz != 0));
        if (sz != 0) begin
            ent = sb_q[0];
            check("head_pc", 64'(bus.PC), 64'(ent[WIDTH+AW-1:WIDTH]));
            check("head_ir", 64'(bus.IR), 64'(ent[WIDTH-1:0]));
        end else begin
            check("empty_ir", 64'(bus.IR), 64'(FB_NOP));
            check("empty_pc", 64'(bus.PC), 64'd0);
        end

        if (bus.imem_req && !mem_busy) begin
            mem_busy = 1'b1;
            lat_left = int'($urandom_range(lat_max, lat_min));
        end
        ack = force_ack || (mem_busy && lat_left == 1);
        if (mem_busy && lat_left > 1) lat_left--;
        data = fixed_en ? fixed_data : WIDTH'($urandom);

        bus.stall      = stl;
        bus.IsBranch   = br;
        bus.BranchAddr = br_addr;
        bus.imem_ack   = ack;
        bus.imem_data  = data;

        push = (m_state == MWait) && ack && !br;
        pop  = (sz != 0) && !stl && !br;
        if (br) begin
            sb_q.delete();
            have_last = 1'b0;
        end else begin
            if (pop) begin
                ent = sb_q.pop_front();
                nxt = last_pc + AW'(1);
                if (have_last) check("pc_seq", 64'(bus.PC), 64'(nxt));
                last_pc   = bus.PC;
                have_last = 1'b1;
                pop_log.push_back(bus.PC);
            end
            if (push) sb_q.push_back({m_addr, data});
        end
        case (m_state)
            MIdle: begin
                if (!br && sz < int'(DEPTH)) begin
                    m_state = MWait;
                    m_addr  = m_pc;
                end
            end
            MWait: begin
                if (ack) begin
                    m_state = MIdle;
                    if (!br) m_pc = m_pc + AW'(1);
                end else if (br) begin
                    m_state = MDrop;
                end
            end
            MDrop: if (ack) m_state = MIdle;
            default: m_state = MIdle;
        endcase
        if (br) m_pc = br_addr;
        if (ack) mem_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ack_during);
        rst           = 1'b1;
        bus.imem_ack  = ack_during;
        bus.imem_data = WIDTH'(32'hBAD0_BAD0);
        bus.IsBranch  = 1'b0;
        bus.stall     = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_ir", 64'(bus.IR), 64'd0);
        check("rst_pc", 64'(bus.PC), 64'd0);
        m_state   = MIdle;
        m_pc      = '0;
        m_addr    = '0;
        have_last = 1'b0;
        mem_busy  = 1'b0;
        lat_left  = 0;
        sb_q.delete();
    endtask

    initial begin
        bus.stall      = 1'b1;
        bus.IsBranch   = 1'b0;
        bus.BranchAddr = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_data  = '0;
        do_reset(1'b0);

        // Fill under stall with latency 1: PCs 0..3 queued, then no further request.
        lat_min = 1; lat_max = 1;
        repeat (12) tick(1'b1, 1'b0, '0, 1'b0);
        check("fill_req_low", 64'(bus.imem_req), 64'd0);
        check("fill_valid", 64'(bus.valid), 64'd1);
        check("fill_head_pc", 64'(bus.PC), 64'd0);

        // Release stall for 6 cycles: consumer sees 0..5 back to back.
        pop_log.delete();
        repeat (6) tick(1'b0, 1'b0, '0, 1'b0);
        check("drain_pops", 64'(pop_log.size()), 64'd6);
        for (int i = 0; i < pop_log.size(); i++) check("drain_pc", 64'(pop_log[i]), 64'(i));

        // Branch while a request to 5 is outstanding; its late data is dropped.
        do_reset(1'b0);
        lat_min = 3; lat_max = 3;
        tick(1'b0, 1'b1, AW'(5), 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("req5_req", 64'(bus.imem_req), 64'd1);
        check("req5_addr", 64'(bus.imem_addr), 64'd5);
        fixed_en = 1'b1; fixed_data = 32'hDEAD_BEEF;
        tick(1'b0, 1'b1, AW'(32'h40), 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        fixed_en = 1'b0;
        check("drop_valid", 64'(bus.valid), 64'd0);
        check("drop_req", 64'(bus.imem_req), 64'd0);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("redir40_req", 64'(bus.imem_req), 64'd1);
        check("redir40_addr", 64'(bus.imem_addr), 64'h40);
        check("redir40_valid", 64'(bus.valid), 64'd0);

        // Branch, ack and pop all in one cycle: the flush wins.
        lat_min = 2; lat_max = 2;
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        lat_min = 1; lat_max = 1;
        check("pre_flush_valid", 64'(bus.valid), 64'd1);
        check("pre_flush_addr", 64'(bus.imem_addr), 64'h41);
        tick(1'b0, 1'b1, AW'(32'h80), 1'b0);
        check("flush_valid", 64'(bus.valid), 64'd0);
        check("flush_pc", 64'(bus.PC), 64'd0);
        check("flush_req", 64'(bus.imem_req), 64'd0);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("redir80_req", 64'(bus.imem_req), 64'd1);
        check("redir80_addr", 64'(bus.imem_addr), 64'h80);

        // Random latency, stall and redirects, including one near the address wrap.
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            logic          b;
            logic [AW-1:0] a;
            b = ($urandom_range(39, 0) == 0) || (i == 1500);
            a = (i == 1500) ? ({AW{1'b1}} - AW'(1)) : AW'($urandom);
            tick($urandom_range(1, 0) == 1, b, a, 1'b0);
        end

        // Reset while waiting on memory with the ack arriving during reset, then a stray ack.
        do_reset(1'b0);
        lat_min = 5; lat_max = 5;
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        do_reset(1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        check("post_rst_req", 64'(bus.imem_req), 64'd1);
        check("post_rst_addr", 64'(bus.imem_addr), 64'd0);
        check("post_rst_valid", 64'(bus.valid), 64'd0);

        // Reset while full.
        lat_min = 1; lat_max = 1;
        repeat (12) tick(1'b1, 1'b0, '0, 1'b0);
        check("full_valid", 64'(bus.valid), 64'd1);
        do_reset(1'b1);
        repeat (4) tick(1'b1, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
